// File: rtl/mac_stage.sv
// mac_stage: multiply-accumulate stage fed by two operand FIFOs (A and B).
// Pops one operand pair per cycle, multiplies them and sums VEC_LEN products
// into a dot product. The result is handed off through a valid/ready handshake.
// Build option: define MAC_SATURATE_EN to clamp the accumulator on overflow.
// Without it the accumulator wraps.
module mac_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned VEC_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  output logic                  a_rden,
  output logic                  b_rden,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  ovf
);

  localparam int unsigned CntWidth  = $clog2(VEC_LEN + 1);
  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  localparam logic [CntWidth-1:0] VecLen  = CntWidth'(VEC_LEN);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(VEC_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    issue_cnt_q;
  logic [CntWidth-1:0]    acc_cnt_q;
  logic                   rd_vld_q;
  logic                   prod_vld_q;
  logic [ProdWidth-1:0]   prod_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_d;
  logic                   ovf_q;
  logic                   pop;
  logic                   accept;
  logic                   last_acc;
  logic [ACC_WIDTH:0]     sum;

  // Pop decode, accumulate datapath and output decode.
  always_comb begin
    // rst gates the enables so they drop the moment reset is asserted.
    pop      = !rst && (state_q == StRun) && !a_empty && !b_empty && (issue_cnt_q < VecLen);
    accept   = (state_q == StIdle) && start;
    last_acc = prod_vld_q && (acc_cnt_q == LastIdx);
    sum      = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_q);
`ifdef MAC_SATURATE_EN
    acc_d    = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    acc_d    = sum[ACC_WIDTH-1:0];
`endif
    a_rden       = pop;
    b_rden       = pop;
    busy         = (state_q != StIdle);
    result_valid = (state_q == StDone);
    result       = acc_q;
    ovf          = ovf_q;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_acc) state_d = StDone;
      StDone:  if (result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Two-stage pipeline: read-data valid, then the registered product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
    end else begin
      rd_vld_q   <= pop;
      prod_vld_q <= rd_vld_q;
      if (rd_vld_q) begin
        prod_q <= ProdWidth'(a_data) * ProdWidth'(b_data);
      end
    end
  end

  // Counters, accumulator and sticky overflow. All are cleared on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      issue_cnt_q <= '0;
      acc_cnt_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (pop) begin
        issue_cnt_q <= issue_cnt_q + CntWidth'(1);
      end
      if (prod_vld_q) begin
        acc_q     <= acc_d;
        acc_cnt_q <= acc_cnt_q + CntWidth'(1);
        if (sum[ACC_WIDTH]) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

endmodule
